// File: rtl/imul_trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : imul_trace_checker
// Brief    : Sequential IMUL transition checker, R multiplier bits per cycle.
//            Optional first-failure log: define IMUL_TRACE_ERRLOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imul_trace_checker #(
   parameter int W      = 32,
   parameter int R      = 4,
   parameter int TSW    = 64,
   parameter int TS_INC = 1,
   parameter int CNTW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic [W-1:0]    in_claim,
   input  logic            in_cf,
   input  logic            in_of,
   input  logic [TSW-1:0]  in_ts,
   input  logic [TSW-1:0]  out_ts,
   input  logic            in_err,
   input  logic            out_err,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            res_pass,
   output logic [3:0]      res_cause,
   output logic [CNTW-1:0] txn_count,
   output logic [CNTW-1:0] fail_count,
   output logic            sticky_fail
`ifdef IMUL_TRACE_ERRLOG_EN
   ,
   output logic [CNTW-1:0] first_fail_idx,
   output logic [3:0]      first_fail_cause
`endif
);

   localparam int              c_STEPS   = W / R;
   localparam int              c_CW      = $clog2(c_STEPS) + 1;
   localparam logic [TSW-1:0]  c_TS_INC  = TSW'(TS_INC);
   localparam logic [CNTW-1:0] c_CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [2*W-1:0]  r_acc, r_mcand, w_pp, w_prod;
   logic [W-1:0]    r_mplier, r_claim;
   logic [c_CW-1:0] r_cnt;
   logic            r_sign, r_cf, r_of, r_in_err, r_out_err;
   logic [TSW-1:0]  r_ts_in, r_ts_out;
   logic            r_pass, r_sticky, w_ovf;
   logic [3:0]      r_cause, w_cause;
   logic [CNTW-1:0] r_txn, r_fail;

   // Two's-complement negate also maps the most negative value to 2^(W-1).
   function automatic logic [W-1:0] f_mag(input logic [W-1:0] v);
      f_mag = v[W-1] ? -v : v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = MUL;
         end
         MUL:   if (r_cnt == c_CW'(c_STEPS - 1)) w_state_nxt = CHECK;
         CHECK: w_state_nxt = HOLD;
         HOLD: begin
            res_valid = 1'b1;
            if (res_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_pp   = r_mcand * {{(2*W-R){1'b0}}, r_mplier[R-1:0]};
      w_prod = r_sign ? -r_acc : r_acc;
      w_ovf  = (w_prod != {{W{w_prod[W-1]}}, w_prod[W-1:0]});
      if (r_in_err) begin
         w_cause = {~r_out_err, 3'b000};
      end else begin
         w_cause = {r_out_err,
                    (r_ts_out != r_ts_in + c_TS_INC),
                    (r_cf != w_ovf) | (r_of != w_ovf),
                    (w_prod[W-1:0] != r_claim)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_claim   <= '0;
         r_cf      <= 1'b0;
         r_of      <= 1'b0;
         r_ts_in   <= '0;
         r_ts_out  <= '0;
         r_in_err  <= 1'b0;
         r_out_err <= 1'b0;
         r_pass    <= 1'b0;
         r_cause   <= '0;
         r_txn     <= '0;
         r_fail    <= '0;
         r_sticky  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_acc     <= '0;
               r_mcand   <= {{W{1'b0}}, f_mag(in_a)};
               r_mplier  <= f_mag(in_b);
               r_sign    <= in_a[W-1] ^ in_b[W-1];
               r_cnt     <= '0;
               r_claim   <= in_claim;
               r_cf      <= in_cf;
               r_of      <= in_of;
               r_ts_in   <= in_ts;
               r_ts_out  <= out_ts;
               r_in_err  <= in_err;
               r_out_err <= out_err;
            end
            MUL: begin
               r_acc    <= r_acc + w_pp;
               r_mcand  <= r_mcand << R;
               r_mplier <= r_mplier >> R;
               r_cnt    <= r_cnt + c_CW'(1);
            end
            CHECK: begin
               r_pass  <= (w_cause == 4'b0000);
               r_cause <= w_cause;
            end
            HOLD: if (res_ready) begin
               if (r_txn != c_CNT_MAX) r_txn <= r_txn + CNTW'(1);
               if (!r_pass) begin
                  r_sticky <= 1'b1;
                  if (r_fail != c_CNT_MAX) r_fail <= r_fail + CNTW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef IMUL_TRACE_ERRLOG_EN
   logic [CNTW-1:0] r_first_idx;
   logic [3:0]      r_first_cause;

   // Pre-increment txn_count gives the zero-based index of the failing verdict.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_first_idx   <= '0;
         r_first_cause <= '0;
      end else if (r_state == HOLD && res_ready && !r_pass && !r_sticky) begin
         r_first_idx   <= r_txn;
         r_first_cause <= r_cause;
      end
   end

   assign first_fail_idx   = r_first_idx;
   assign first_fail_cause = r_first_cause;
`endif

   assign res_pass    = r_pass;
   assign res_cause   = r_cause;
   assign txn_count   = r_txn;
   assign fail_count  = r_fail;
   assign sticky_fail = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_imul_trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_imul_trace_checker
// Brief    : Directed self-checking bench for imul_trace_checker (W=32, R=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imul_trace_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0, in_claim = '0;
   logic        in_cf = 1'b0, in_of = 1'b0;
   logic [63:0] in_ts = '0, out_ts = '0;
   logic        in_err = 1'b0, out_err = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        res_pass;
   logic [3:0]  res_cause;
   logic [15:0] txn_count, fail_count;
   logic        sticky_fail;
`ifdef IMUL_TRACE_ERRLOG_EN
   logic [15:0] first_fail_idx;
   logic [3:0]  first_fail_cause;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_txn = 0;
   int exp_fail = 0;
   int lat;

   always #5 clk = ~clk;

   imul_trace_checker #(.W(32), .R(4), .TSW(64), .TS_INC(1), .CNTW(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_claim(in_claim),
      .in_cf(in_cf), .in_of(in_of),
      .in_ts(in_ts), .out_ts(out_ts),
      .in_err(in_err), .out_err(out_err),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_pass(res_pass), .res_cause(res_cause),
      .txn_count(txn_count), .fail_count(fail_count),
      .sticky_fail(sticky_fail)
`ifdef IMUL_TRACE_ERRLOG_EN
      ,
      .first_fail_idx(first_fail_idx),
      .first_fail_cause(first_fail_cause)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one record and wait (bounded) for its verdict; leaves it unconsumed.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] claim,
                       input logic cf, input logic of_, input logic [63:0] tsi,
                       input logic [63:0] tso, input logic ie, input logic oe);
      int guard = 0;
      while (!in_ready && guard < 40) begin step(); guard++; end
      chk("in_ready_before_send", in_ready, 1'b1);
      in_a = a; in_b = b; in_claim = claim; in_cf = cf; in_of = of_;
      in_ts = tsi; out_ts = tso; in_err = ie; out_err = oe;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 40) begin step(); lat++; end
   endtask

   task automatic consume(input logic exp_pass);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      exp_txn++;
      if (!exp_pass) exp_fail++;
      chk("txn_count", txn_count, 64'(exp_txn));
      chk("fail_count", fail_count, 64'(exp_fail));
      chk("sticky_fail", sticky_fail, (exp_fail != 0) ? 64'd1 : 64'd0);
      chk("in_ready_after_consume", in_ready, 1'b1);
   endtask

   task automatic verdict(input string tag, input logic exp_pass, input logic [3:0] exp_cause);
      chk({tag, "_latency"}, 64'(lat), 64'd9);
      chk({tag, "_pass"}, res_pass, exp_pass);
      chk({tag, "_cause"}, res_cause, exp_cause);
      consume(exp_pass);
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_res_valid", res_valid, 1'b0);
      chk("reset_res_pass", res_pass, 1'b0);
      chk("reset_res_cause", res_cause, 4'h0);
      chk("reset_txn", txn_count, 16'h0);
      chk("reset_fail", fail_count, 16'h0);
      chk("reset_sticky", sticky_fail, 1'b0);

      // -2 * 3 = -6, no overflow
      send(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 0, 0, 64'd100, 64'd101, 0, 0);
      verdict("neg_times_pos", 1'b1, 4'b0000);

      // 2^16 * 2^16 = 2^32 overflows
      send(32'h0001_0000, 32'h0001_0000, 32'h0, 1, 1, 64'd5, 64'd6, 0, 0);
      verdict("ovf_flags_set", 1'b1, 4'b0000);
      send(32'h0001_0000, 32'h0001_0000, 32'h0, 0, 0, 64'd5, 64'd6, 0, 0);
      verdict("ovf_flags_clear", 1'b0, 4'b0010);
`ifdef IMUL_TRACE_ERRLOG_EN
      chk("errlog_idx", first_fail_idx, 16'd2);
      chk("errlog_cause", first_fail_cause, 4'h2);
`endif

      // most negative * -1 = +2^31, does not fit
      send(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 64'd7, 64'd8, 0, 0);
      verdict("minint_ok", 1'b1, 4'b0000);
      send(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 1, 64'd7, 64'd8, 0, 0);
      verdict("minint_bad_claim", 1'b0, 4'b0001);
`ifdef IMUL_TRACE_ERRLOG_EN
      chk("errlog_idx_kept", first_fail_idx, 16'd2);
      chk("errlog_cause_kept", first_fail_cause, 4'h2);
`endif

      // timestamp wrap
      send(32'd2, 32'd3, 32'd6, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0);
      verdict("ts_wrap", 1'b1, 4'b0000);
      send(32'd2, 32'd3, 32'd6, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0);
      verdict("ts_bad", 1'b0, 4'b0100);

      // error flag propagation
      send(32'd2, 32'd3, 32'd7, 0, 0, 64'd1, 64'd9, 1, 0);
      verdict("err_dropped", 1'b0, 4'b1000);
      send(32'd2, 32'd3, 32'd7, 1, 0, 64'd1, 64'd9, 1, 1);
      verdict("err_kept", 1'b1, 4'b0000);
      send(32'd2, 32'd3, 32'd6, 0, 0, 64'd1, 64'd2, 0, 1);
      verdict("err_raised", 1'b0, 4'b1000);

      // back-pressure: verdict holds while res_ready is low
      send(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 64'd10, 64'd11, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_pass", res_pass, 1'b1);
         chk("hold_cause", res_cause, 4'b0000);
         chk("hold_in_ready", in_ready, 1'b0);
         step();
      end
      verdict("hold_release", 1'b1, 4'b0000);

      // reset in the third MUL cycle abandons the record
      send_abort();
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_res_valid", res_valid, 1'b0);
      chk("abort_txn", txn_count, 16'h0);
      chk("abort_fail", fail_count, 16'h0);
      chk("abort_sticky", sticky_fail, 1'b0);
`ifdef IMUL_TRACE_ERRLOG_EN
      chk("abort_errlog_idx", first_fail_idx, 16'h0);
      chk("abort_errlog_cause", first_fail_cause, 4'h0);
`endif
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 15; i++) begin
            step();
            if (res_valid) seen = 1'b1;
         end
         chk("abort_no_verdict", seen, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   task automatic send_abort();
      in_a = 32'd3; in_b = 32'd5; in_claim = 32'd15;
      in_ts = 64'd0; out_ts = 64'd1; in_err = 1'b0; out_err = 1'b0;
      in_cf = 1'b0; in_of = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_txn = 0;
      exp_fail = 0;
   endtask

endmodule
`default_nettype wire
